sm3_ahb_regfile: RTL and testbench
==================================

Name: sm3_ahb_regfile

Overview:
- Parametrised successor of the SM3 AHB slave register bank.
- Provides full AHB-Lite address/data-phase pipelining and a start/busy/done handshake to the SM3 hash core.
- Result capture is triggered by the core, not by bus writes; status is sticky write-1-to-clear with a maskable interrupt.
- Sits between the AHB interconnect and the SM3 core/DMA address generator.

Parameters:
- NUM_RES, 8, number of 32-bit result words; TEMP_RES/LAST_RES width is 32*NUM_RES; legal range 1..(2^AW - 5).
- ADDR_W, 13, width of SAR_ADDR and BSR.
- AW, 5, word-index bits taken from AHB_HADDR[AW+1:2].

Ports:
- AHB_HCLK  in  1  sole clock; all state updates on rising edge.
- AHB_HRESET  in  1  synchronous, active-high reset.
- AHB_HSEL  in  1  slave select.
- AHB_HTRANS  in  2  only bit 1 is used (NONSEQ/SEQ = valid transfer).
- AHB_HREADY  in  1  bus ready; address phase is accepted only when high.
- AHB_HWRITE  in  1  1 = write.
- AHB_HADDR  in  AW  word address, bits [AW+1:2].
- AHB_HWDATA  in  32  write data, sampled in the data phase.
- AHB_HRDATA  out  32  read data, valid in the data phase.
- AHB_HREADYOUT  out  1  tied 1 (zero wait states).
- AHB_HRESP  out  1  tied 0 (OKAY).
- TEMP_RES  in  32*NUM_RES  core result bus.
- CORE_DONE  in  1  one-cycle pulse from the core: result valid.
- CORE_START  out  1  one-cycle start pulse to the core.
- CORE_ABORT  out  1  one-cycle abort pulse.
- ENABLE  out  1  CTRL.EN.
- SAR_ADDR  out  ADDR_W  source address register.
- BSR  out  ADDR_W  block-count register.
- LAST_RES  out  32*NUM_RES  captured result.
- CRYPT_INTR  out  1  interrupt, level-sensitive.

Behaviour:
- Reset: all registers 0; CORE_START=0, CORE_ABORT=0, CRYPT_INTR=0, AHB_HRDATA=0.

Register map (word index):
- 0 CTRL: bit0 EN (RW); bit1 START (write-only, reads 0).
- 1 SAR (RW, [ADDR_W-1:0]).
- 2 BSR (RW, [ADDR_W-1:0]).
- 3 IMR: bit0 MASK (RW, 1 = masked).
- 4 STR: bit0 DONE (W1C); bit1 BUSY (RO).
- 5..5+NUM_RES-1 RES[i] = LAST_RES[32i+31:32i] (RO).
- Unmapped indices: read 0, writes ignored, OKAY response. Unused upper bits read 0.

AHB pipeline:
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, latch index and HWRITE into a data-phase register, and set a valid flag.
- Otherwise (HREADY high) the valid flag clears.
- Write data is applied at the end of the data phase (the edge after the accepted address phase), using HWDATA.
- Reads: HRDATA is driven combinationally from the latched index during the data phase. It is 0 when no read is pending.
- Back-to-back transfers work at one per cycle. A read following a write to the same register returns the new value.

Start handshake:
- A data-phase write to CTRL with HWDATA[1]=1, while the resulting EN=1 and BUSY=0, pulses CORE_START on the next cycle and sets BUSY.
- EN and START may be set in the same write.
- START while BUSY=1 or EN=0 is ignored; no pulse is generated.

Completion:
- CORE_DONE while BUSY: capture TEMP_RES into all RES registers, set DONE, clear BUSY (one edge).
- CORE_DONE while not BUSY is ignored; no capture.

Abort:
- A write clearing EN while BUSY=1 clears BUSY and pulses CORE_ABORT for one cycle. DONE is unchanged.
- CORE_DONE in the same cycle as the abort write: the abort wins, with no capture.

W1C and start collisions:
- W1C of DONE in the same cycle as a CORE_DONE capture: DONE stays 1 (set wins).
- CORE_DONE in the same cycle as a START write (BUSY was 1): complete first; the START is ignored.

Interrupt:
- CRYPT_INTR = DONE & ~MASK, combinational from registers.

Reset mid-transfer:
- Drops the pending data phase and clears BUSY.
- No CORE_ABORT or CORE_START pulse is generated in the reset cycle.

Test Plan:
- Reset, then read every index 0..5+NUM_RES and 31 -> all return 0x00000000; HREADYOUT=1, HRESP=0 throughout.
- Write SAR=0x1ABC, BSR=0x0003, then read both back-to-back -> 0x00001ABC, 0x00000003; SAR_ADDR and BSR track the values one edge after each data phase. Repeat with ADDR_W=16, write 0xFFFF_1234 -> reads 0x00001234.
- Write CTRL=0x3 -> CORE_START high for exactly one cycle, STR reads 0x2. Write CTRL=0x3 again -> no pulse. Drive TEMP_RES word i = 0xA5A50000+i with CORE_DONE -> RES[i] reads 0xA5A50000+i, STR reads 0x1, CRYPT_INTR=1.
- With DONE=1, write IMR=1 -> CRYPT_INTR=0. Write STR=0x1 -> DONE=0. Then write STR=0x1 in the same cycle as CORE_DONE -> DONE remains 1.
- While BUSY, write CTRL=0x0 with CORE_DONE asserted in the same cycle -> CORE_ABORT pulses once, RES unchanged, BUSY=0, DONE unchanged.
- Mid-transfer AHB_HRESET during an outstanding write data phase -> target register stays 0, BUSY=0, next transfer behaves normally. Also: HTRANS=IDLE and HREADY=0 address phases -> no register change.

Source files
------------

// File: rtl/sm3_ahb_regfile.sv
// AHB-Lite slave register bank for the SM3 hash core: control, DMA address/count,
// start/busy/done handshake, captured result words and a maskable done interrupt.
module sm3_ahb_regfile #(
    parameter int unsigned NUM_RES = 8,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned AW      = 5
) (
    input  logic                  AHB_HCLK,
    input  logic                  AHB_HRESET,
    input  logic                  AHB_HSEL,
    input  logic [1:0]            AHB_HTRANS,
    input  logic                  AHB_HREADY,
    input  logic                  AHB_HWRITE,
    input  logic [AW-1:0]         AHB_HADDR,
    input  logic [31:0]           AHB_HWDATA,
    output logic [31:0]           AHB_HRDATA,
    output logic                  AHB_HREADYOUT,
    output logic                  AHB_HRESP,
    input  logic [32*NUM_RES-1:0] TEMP_RES,
    input  logic                  CORE_DONE,
    output logic                  CORE_START,
    output logic                  CORE_ABORT,
    output logic                  ENABLE,
    output logic [ADDR_W-1:0]     SAR_ADDR,
    output logic [ADDR_W-1:0]     BSR,
    output logic [32*NUM_RES-1:0] LAST_RES,
    output logic                  CRYPT_INTR
);

    localparam int unsigned RES_W    = 32 * NUM_RES;
    localparam int unsigned RES_BASE = 5;

    localparam logic [AW-1:0] IDX_CTRL = AW'(0);
    localparam logic [AW-1:0] IDX_SAR  = AW'(1);
    localparam logic [AW-1:0] IDX_BSR  = AW'(2);
    localparam logic [AW-1:0] IDX_IMR  = AW'(3);
    localparam logic [AW-1:0] IDX_STR  = AW'(4);

    typedef struct packed {
        logic          valid;
        logic          write;
        logic [AW-1:0] idx;
    } dphase_t;

    dphase_t            dp_q, dp_d;
    logic               en_q, en_d;
    logic [ADDR_W-1:0]  sar_q, sar_d;
    logic [ADDR_W-1:0]  bsr_q, bsr_d;
    logic               mask_q, mask_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic               abort_q, abort_d;
    logic [RES_W-1:0]   res_q, res_d;

    logic               addr_accept_c;
    logic               wr_c;
    logic               wr_ctrl_c;
    logic               capture_c;
    logic [31:0]        rdata_c;
    logic               unused_c;

    // Bits of the bus that carry no meaning for this register bank
    assign unused_c = ^{AHB_HTRANS[0], AHB_HWDATA};

    // Address phase -> data phase pipeline register; holds while the bus stalls
    always_comb begin
        dp_d          = dp_q;
        addr_accept_c = AHB_HSEL & AHB_HTRANS[1] & AHB_HREADY;
        if (AHB_HREADY) begin
            dp_d.valid = addr_accept_c;
            dp_d.write = AHB_HWRITE;
            dp_d.idx   = AHB_HADDR;
        end
    end

    // Register updates: bus writes, start/abort handshake, result capture
    always_comb begin
        en_d      = en_q;
        sar_d     = sar_q;
        bsr_d     = bsr_q;
        mask_d    = mask_q;
        done_d    = done_q;
        busy_d    = busy_q;
        res_d     = res_q;
        start_d   = 1'b0;
        abort_d   = 1'b0;

        wr_c      = dp_q.valid & dp_q.write & AHB_HREADY;
        wr_ctrl_c = wr_c & (dp_q.idx == IDX_CTRL);

        if (wr_ctrl_c) begin
            en_d = AHB_HWDATA[0];
            if (busy_q && !AHB_HWDATA[0]) begin
                abort_d = 1'b1;
            end else if (!busy_q && AHB_HWDATA[0] && AHB_HWDATA[1]) begin
                start_d = 1'b1;
            end
        end

        // An abort in the same cycle suppresses the completion entirely
        capture_c = CORE_DONE & busy_q & ~abort_d;

        if (wr_c && (dp_q.idx == IDX_SAR)) begin
            sar_d = AHB_HWDATA[ADDR_W-1:0];
        end
        if (wr_c && (dp_q.idx == IDX_BSR)) begin
            bsr_d = AHB_HWDATA[ADDR_W-1:0];
        end
        if (wr_c && (dp_q.idx == IDX_IMR)) begin
            mask_d = AHB_HWDATA[0];
        end
        if (wr_c && (dp_q.idx == IDX_STR) && AHB_HWDATA[0]) begin
            done_d = 1'b0;
        end

        if (capture_c) begin
            res_d  = TEMP_RES;
            done_d = 1'b1;
        end

        if (abort_d || capture_c) begin
            busy_d = 1'b0;
        end else if (start_d) begin
            busy_d = 1'b1;
        end
    end

    // Read mux, driven from the latched data-phase index
    always_comb begin
        rdata_c = '0;
        if (dp_q.valid && !dp_q.write) begin
            case (dp_q.idx)
                IDX_CTRL: rdata_c[0]          = en_q;
                IDX_SAR:  rdata_c[ADDR_W-1:0] = sar_q;
                IDX_BSR:  rdata_c[ADDR_W-1:0] = bsr_q;
                IDX_IMR:  rdata_c[0]          = mask_q;
                IDX_STR:  rdata_c[1:0]        = {busy_q, done_q};
                default: begin
                    for (int i = 0; i < int'(NUM_RES); i++) begin
                        if (dp_q.idx == AW'(RES_BASE + 32'(i))) begin
                            rdata_c = res_q[32*i +: 32];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge AHB_HCLK) begin
        if (AHB_HRESET) begin
            dp_q    <= '0;
            en_q    <= 1'b0;
            sar_q   <= '0;
            bsr_q   <= '0;
            mask_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            res_q   <= '0;
        end else begin
            dp_q    <= dp_d;
            en_q    <= en_d;
            sar_q   <= sar_d;
            bsr_q   <= bsr_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            abort_q <= abort_d;
            res_q   <= res_d;
        end
    end

    assign AHB_HRDATA    = rdata_c;
    assign AHB_HREADYOUT = 1'b1;
    assign AHB_HRESP     = 1'b0;
    assign CORE_START    = start_q;
    assign CORE_ABORT    = abort_q;
    assign ENABLE        = en_q;
    assign SAR_ADDR      = sar_q;
    assign BSR           = bsr_q;
    assign LAST_RES      = res_q;
    assign CRYPT_INTR    = done_q & ~mask_q;

endmodule

// File: tb/tb_sm3_ahb_regfile.sv
// Randomised and directed bench for sm3_ahb_regfile against a transaction-level register model.
module tb_sm3_ahb_regfile;

    localparam int unsigned NUM_RES = 8;
    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned AW      = 5;

    logic                  clk = 1'b0;
    logic                  AHB_HRESET = 1'b1;
    logic                  AHB_HSEL = 1'b0;
    logic [1:0]            AHB_HTRANS = 2'b00;
    logic                  AHB_HREADY = 1'b1;
    logic                  AHB_HWRITE = 1'b0;
    logic [AW-1:0]         AHB_HADDR = '0;
    logic [31:0]           AHB_HWDATA = '0;
    logic [31:0]           AHB_HRDATA;
    logic                  AHB_HREADYOUT;
    logic                  AHB_HRESP;
    logic [32*NUM_RES-1:0] TEMP_RES = '0;
    logic                  CORE_DONE = 1'b0;
    logic                  CORE_START;
    logic                  CORE_ABORT;
    logic                  ENABLE;
    logic [ADDR_W-1:0]     SAR_ADDR;
    logic [ADDR_W-1:0]     BSR;
    logic [32*NUM_RES-1:0] LAST_RES;
    logic                  CRYPT_INTR;

    always #5 clk = ~clk;

    sm3_ahb_regfile #(.NUM_RES(NUM_RES), .ADDR_W(ADDR_W), .AW(AW)) dut (
        .AHB_HCLK(clk), .AHB_HRESET(AHB_HRESET), .AHB_HSEL(AHB_HSEL),
        .AHB_HTRANS(AHB_HTRANS), .AHB_HREADY(AHB_HREADY), .AHB_HWRITE(AHB_HWRITE),
        .AHB_HADDR(AHB_HADDR), .AHB_HWDATA(AHB_HWDATA), .AHB_HRDATA(AHB_HRDATA),
        .AHB_HREADYOUT(AHB_HREADYOUT), .AHB_HRESP(AHB_HRESP), .TEMP_RES(TEMP_RES),
        .CORE_DONE(CORE_DONE), .CORE_START(CORE_START), .CORE_ABORT(CORE_ABORT),
        .ENABLE(ENABLE), .SAR_ADDR(SAR_ADDR), .BSR(BSR), .LAST_RES(LAST_RES),
        .CRYPT_INTR(CRYPT_INTR)
    );

    int tests = 0;
    int fails = 0;
    bit checking = 0;

    // Model state: register contents, pending bus transfer and handshake pulses
    bit          m_en, m_mask, m_done, m_busy, m_start, m_abort;
    logic [31:0] m_sar, m_bsr;
    logic [31:0] m_res [NUM_RES];
    bit          m_pv, m_pw;
    int          m_pidx;
    logic [31:0] pend_wd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int idx);
        logic [31:0] v;
        v = 32'h0;
        if (idx == 0)      v = {31'h0, m_en};
        else if (idx == 1) v = m_sar;
        else if (idx == 2) v = m_bsr;
        else if (idx == 3) v = {31'h0, m_mask};
        else if (idx == 4) v = {30'h0, m_busy, m_done};
        else if (idx >= 5 && idx < 5 + int'(NUM_RES)) v = m_res[idx-5];
        return v;
    endfunction

    // Apply one clock edge to the model using the inputs the bench is driving
    task automatic model_step();
        bit wr, ctrl_wr, st, ab, cap;
        logic [31:0] wd;
        if (AHB_HRESET) begin
            m_en = 0; m_mask = 0; m_done = 0; m_busy = 0; m_start = 0; m_abort = 0;
            m_sar = 0; m_bsr = 0; m_pv = 0; m_pw = 0; m_pidx = 0;
            for (int i = 0; i < int'(NUM_RES); i++) m_res[i] = 0;
            return;
        end
        wd = AHB_HWDATA;
        wr = m_pv && m_pw && AHB_HREADY;
        ctrl_wr = wr && (m_pidx == 0);
        ab = ctrl_wr && m_busy && !wd[0];
        st = ctrl_wr && !m_busy && wd[0] && wd[1];
        cap = CORE_DONE && m_busy && !ab;
        if (ctrl_wr) m_en = wd[0];
        if (wr && m_pidx == 1) m_sar = wd & ((32'd1 << ADDR_W) - 1);
        if (wr && m_pidx == 2) m_bsr = wd & ((32'd1 << ADDR_W) - 1);
        if (wr && m_pidx == 3) m_mask = wd[0];
        if (wr && m_pidx == 4 && wd[0]) m_done = 0;
        if (cap) begin
            m_done = 1;
            for (int i = 0; i < int'(NUM_RES); i++) m_res[i] = TEMP_RES[32*i +: 32];
        end
        if (ab || cap) m_busy = 0;
        if (st) m_busy = 1;
        m_start = st;
        m_abort = ab;
        if (AHB_HREADY) begin
            m_pv = AHB_HSEL && AHB_HTRANS[1];
            m_pw = AHB_HWRITE;
            m_pidx = int'(AHB_HADDR);
        end
    endtask

    // One bus cycle: new address phase plus write data for the previous one
    task automatic bus(input bit sel, input bit [1:0] trans, input bit rdy, input bit wr,
                       input int idx, input logic [31:0] wdata, input bit cdone, input bit rst);
        AHB_HSEL   = sel;
        AHB_HTRANS = trans;
        AHB_HREADY = rdy;
        AHB_HWRITE = wr;
        AHB_HADDR  = AW'(idx);
        AHB_HWDATA = pend_wd;
        pend_wd    = wdata;
        CORE_DONE  = cdone;
        AHB_HRESET = rst;
        @(posedge clk);
        model_step();
        checking = 1;
        #1;
    endtask

    task automatic wr_reg(input int idx, input logic [31:0] d);
        bus(1, 2'b10, 1, 1, idx, d, 0, 0);
    endtask

    task automatic rd_reg(input int idx);
        bus(1, 2'b10, 1, 0, idx, 32'h0, 0, 0);
    endtask

    task automatic idle(input bit cdone);
        bus(0, 2'b00, 1, 0, 0, 32'h0, cdone, 0);
    endtask

    task automatic set_temp(input logic [31:0] base);
        for (int i = 0; i < int'(NUM_RES); i++) TEMP_RES[32*i +: 32] = base + 32'(i);
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("hrdata", AHB_HRDATA, (m_pv && !m_pw) ? m_read(m_pidx) : 32'h0);
            chk("hreadyout", 32'(AHB_HREADYOUT), 32'h1);
            chk("hresp", 32'(AHB_HRESP), 32'h0);
            chk("core_start", 32'(CORE_START), 32'(m_start));
            chk("core_abort", 32'(CORE_ABORT), 32'(m_abort));
            chk("enable", 32'(ENABLE), 32'(m_en));
            chk("sar_addr", 32'(SAR_ADDR), m_sar);
            chk("bsr", 32'(BSR), m_bsr);
            chk("crypt_intr", 32'(CRYPT_INTR), 32'(m_done && !m_mask));
            for (int i = 0; i < int'(NUM_RES); i++)
                chk("last_res", LAST_RES[32*i +: 32], m_res[i]);
        end
    end

    initial begin
        bus(0, 2'b00, 1, 0, 0, 0, 0, 1);
        bus(0, 2'b00, 1, 0, 0, 0, 0, 1);

        // Everything reads zero after reset
        for (int i = 0; i <= 5 + int'(NUM_RES); i++) begin
            rd_reg(i);
            chk("rst_read", AHB_HRDATA, 32'h0);
        end
        rd_reg(31);
        chk("rst_read31", AHB_HRDATA, 32'h0);

        // SAR/BSR write then back-to-back reads
        wr_reg(1, 32'h0000_1ABC);
        wr_reg(2, 32'h0000_0003);
        chk("sar_track", 32'(SAR_ADDR), 32'h0000_1ABC);
        rd_reg(1);
        chk("rd_sar", AHB_HRDATA, 32'h0000_1ABC);
        rd_reg(2);
        chk("rd_bsr", AHB_HRDATA, 32'h0000_0003);
        chk("bsr_track", 32'(BSR), 32'h0000_0003);
        wr_reg(1, 32'hFFFF_1234);
        rd_reg(1);
        chk("rd_sar_trunc", AHB_HRDATA, 32'h0000_1234);

        // Start pulse, BUSY, ignored second start
        wr_reg(0, 32'h3);
        idle(0);
        chk("start_pulse", 32'(CORE_START), 32'h1);
        idle(0);
        chk("start_single", 32'(CORE_START), 32'h0);
        rd_reg(4);
        chk("str_busy", AHB_HRDATA, 32'h2);
        wr_reg(0, 32'h3);
        idle(0);
        chk("start_ignored", 32'(CORE_START), 32'h0);

        // Completion captures result words
        set_temp(32'hA5A5_0000);
        idle(1);
        set_temp(32'h0);
        for (int i = 0; i < int'(NUM_RES); i++) begin
            rd_reg(5 + i);
            chk("rd_res", AHB_HRDATA, 32'hA5A5_0000 + 32'(i));
        end
        rd_reg(4);
        chk("str_done", AHB_HRDATA, 32'h1);
        chk("intr_set", 32'(CRYPT_INTR), 32'h1);

        // Mask, W1C, and W1C colliding with a capture
        wr_reg(3, 32'h1);
        idle(0);
        chk("intr_masked", 32'(CRYPT_INTR), 32'h0);
        wr_reg(4, 32'h1);
        idle(0);
        rd_reg(4);
        chk("str_cleared", AHB_HRDATA, 32'h0);
        wr_reg(0, 32'h3);
        wr_reg(4, 32'h1);
        set_temp(32'h5A5A_0000);
        idle(1);
        rd_reg(4);
        chk("w1c_vs_set", AHB_HRDATA, 32'h1);
        rd_reg(5);
        chk("rd_res2", AHB_HRDATA, 32'h5A5A_0000);

        // Abort beats a simultaneous completion
        wr_reg(0, 32'h3);
        wr_reg(0, 32'h0);
        set_temp(32'hDEAD_0000);
        idle(1);
        chk("abort_pulse", 32'(CORE_ABORT), 32'h1);
        idle(0);
        chk("abort_single", 32'(CORE_ABORT), 32'h0);
        rd_reg(4);
        chk("str_after_abort", AHB_HRDATA, 32'h1);
        rd_reg(5);
        chk("res_kept", AHB_HRDATA, 32'h5A5A_0000);

        // Reset during an outstanding write data phase
        wr_reg(0, 32'h3);
        wr_reg(2, 32'h55);
        bus(0, 2'b00, 1, 0, 0, 0, 0, 1);
        rd_reg(2);
        chk("rst_mid_bsr", AHB_HRDATA, 32'h0);
        rd_reg(4);
        chk("rst_mid_str", AHB_HRDATA, 32'h0);
        wr_reg(2, 32'h7);
        rd_reg(2);
        chk("post_rst_bsr", AHB_HRDATA, 32'h7);

        // IDLE and HREADY-low address phases must not write
        bus(1, 2'b00, 1, 1, 2, 32'h99, 0, 0);
        rd_reg(2);
        chk("idle_nowrite", AHB_HRDATA, 32'h7);
        bus(1, 2'b10, 0, 1, 2, 32'h99, 0, 0);
        rd_reg(2);
        chk("nready_nowrite", AHB_HRDATA, 32'h7);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int idx;
            logic [31:0] d;
            for (int i = 0; i < int'(NUM_RES); i++) TEMP_RES[32*i +: 32] = $urandom;
            idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                               : int'($urandom_range(0, 6));
            d = $urandom;
            if (idx == 0) d = {30'h0, 2'($urandom_range(0, 3))};
            bus($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), idx, d,
                $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end
        idle(0);
        idle(0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
